// File: rtl/pipeline_exec_controller.sv
// ============================================================================
// Module   : pipeline_exec_controller
// Purpose  : Run / step-N / stop sequencer driving the pipeline advance enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_exec_controller #(
  parameter int NB_CYCLES = 32,
  parameter int NB_STEPS  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  input  logic [NB_STEPS-1:0]  i_step_count,
  input  logic                 i_halt_wb,
  output logic                 o_cmd_ready,
  output logic                 o_step,
  output logic                 o_running,
  output logic                 o_halted,
  output logic                 o_step_done,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  logic [1:0]           state, next_state;
  logic [NB_STEPS-1:0]  remaining, next_remaining;
  logic                 step_done, next_step_done;
  logic [NB_CYCLES-1:0] cycle_count;
  logic                 cmd_accept;

  // Commands are only taken outside a STEP burst; others are dropped.
  assign cmd_accept = i_cmd_valid && (state != ST_STEP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      step_done   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= next_state;
      remaining <= next_remaining;
      step_done <= next_step_done;
      if ((state == ST_RUN) || (state == ST_STEP))
        cycle_count <= cycle_count + NB_CYCLES'(1);
    end
  end

  always_comb begin
    next_state     = state;
    next_remaining = remaining;
    next_step_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_accept && (i_cmd == CMD_RUN)) begin
          next_state = ST_RUN;
        end else if (cmd_accept && (i_cmd == CMD_STEP)) begin
          next_state     = ST_STEP;
          next_remaining = (i_step_count == '0) ? NB_STEPS'(1) : i_step_count;
        end
      end
      ST_RUN: begin
        // Halt takes priority over a simultaneous STOP.
        if (i_halt_wb)
          next_state = ST_HALTED;
        else if (cmd_accept && (i_cmd == CMD_STOP))
          next_state = ST_IDLE;
      end
      ST_STEP: begin
        next_remaining = remaining - NB_STEPS'(1);
        if (i_halt_wb) begin
          next_state     = ST_HALTED;
          next_step_done = 1'b1;
        end else if (remaining <= NB_STEPS'(1)) begin
          next_state     = ST_IDLE;
          next_step_done = 1'b1;
        end
      end
      ST_HALTED: begin
        if (cmd_accept && (i_cmd == CMD_STOP))
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so o_step is stable at the negedge.
  always_comb begin
    o_step        = (state == ST_RUN) || (state == ST_STEP);
    o_running     = (state == ST_RUN);
    o_halted      = (state == ST_HALTED);
    o_cmd_ready   = (state != ST_STEP);
    o_step_done   = step_done;
    o_cycle_count = cycle_count;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_exec_controller.sv
// Testbench for pipeline_exec_controller: directed scenarios plus randomized run vs. model.
`default_nettype none

module tb_pipeline_exec_controller;

  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, STOP = 2'b11;

  logic        clk, rst, cmd_valid, halt_wb;
  logic [1:0]  cmd;
  logic [7:0]  step_count;
  logic        cmd_ready, step, running, halted, step_done;
  logic [31:0] cycle_count;
  logic        cmd_ready4, step4, running4, halted4, step_done4;
  logic [3:0]  cycle_count4;

  int checks = 0;
  int errors = 0;

  pipeline_exec_controller dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_step_count(step_count), .i_halt_wb(halt_wb),
    .o_cmd_ready(cmd_ready), .o_step(step), .o_running(running),
    .o_halted(halted), .o_step_done(step_done), .o_cycle_count(cycle_count)
  );

  pipeline_exec_controller #(.NB_CYCLES(4), .NB_STEPS(8)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_step_count(step_count), .i_halt_wb(halt_wb),
    .o_cmd_ready(cmd_ready4), .o_step(step4), .o_running(running4),
    .o_halted(halted4), .o_step_done(step_done4), .o_cycle_count(cycle_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] n);
    cmd_valid = 1'b1; cmd = c; step_count = n;
    tick();
    cmd_valid = 1'b0; cmd = NOP; step_count = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd = RUN; halt_wb = 1'b1;
    do_reset();
    cmd_valid = 1'b0; cmd = NOP; halt_wb = 1'b0;
    checks++; if (step !== 1'b0)        begin errors++; $display("FAIL reset_step got %b exp 0", step); end
    checks++; if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    checks++; if (running !== 1'b0)     begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (step_done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", step_done); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
  endtask

  task automatic test_run_halt();
    do_reset();
    issue(RUN, 8'd0);
    for (int i = 1; i <= 9; i++) begin
      checks++; if (step !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL run_step cyc%0d got step=%b run=%b exp 1/1", i, step, running); end
      tick();
    end
    halt_wb = 1'b1;
    tick();
    halt_wb = 1'b0;
    checks++; if (halted !== 1'b1)        begin errors++; $display("FAIL run_halt_halted got %b exp 1", halted); end
    checks++; if (running !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL run_halt_run got run=%b step=%b exp 0/0", running, step); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL run_halt_count got %0d exp 10", cycle_count); end
    issue(STOP, 8'd0);
    checks++; if (halted !== 1'b0 || cycle_count !== 32'd10) begin errors++; $display("FAIL run_halt_stop got halted=%b cnt=%0d exp 0/10", halted, cycle_count); end
  endtask

  task automatic test_step_n(input logic [7:0] n, input int exp_cycles);
    do_reset();
    issue(STEP, n);
    for (int i = 0; i < exp_cycles; i++) begin
      checks++; if (step !== 1'b1 || cmd_ready !== 1'b0 || step_done !== 1'b0) begin errors++; $display("FAIL step%0d_burst cyc%0d got step=%b rdy=%b done=%b exp 1/0/0", n, i, step, cmd_ready, step_done); end
      tick();
    end
    checks++; if (step !== 1'b0 || step_done !== 1'b1) begin errors++; $display("FAIL step%0d_end got step=%b done=%b exp 0/1", n, step, step_done); end
    checks++; if (cmd_ready !== 1'b1 || running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL step%0d_idle got rdy=%b run=%b halt=%b exp 1/0/0", n, cmd_ready, running, halted); end
    checks++; if (cycle_count !== 32'(exp_cycles)) begin errors++; $display("FAIL step%0d_count got %0d exp %0d", n, cycle_count, exp_cycles); end
    tick();
    checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL step%0d_pulse got %b exp 0", n, step_done); end
  endtask

  task automatic test_step_halt();
    do_reset();
    issue(STEP, 8'd5);
    tick();
    halt_wb = 1'b1;
    tick();
    halt_wb = 1'b0;
    checks++; if (halted !== 1'b1 || step_done !== 1'b1 || step !== 1'b0) begin errors++; $display("FAIL step_halt got halt=%b done=%b step=%b exp 1/1/0", halted, step_done, step); end
    checks++; if (cycle_count !== 32'd2) begin errors++; $display("FAIL step_halt_count got %0d exp 2", cycle_count); end
    issue(RUN, 8'd0);
    checks++; if (halted !== 1'b1 || step !== 1'b0) begin errors++; $display("FAIL halted_run_ignored got halt=%b step=%b exp 1/0", halted, step); end
    issue(STOP, 8'd0);
    checks++; if (halted !== 1'b0 || cmd_ready !== 1'b1 || cycle_count !== 32'd2) begin errors++; $display("FAIL halted_stop got halt=%b rdy=%b cnt=%0d exp 0/1/2", halted, cmd_ready, cycle_count); end
  endtask

  task automatic test_run_stop_halt();
    do_reset();
    issue(RUN, 8'd0);
    tick();
    halt_wb = 1'b1;
    issue(STOP, 8'd0);
    halt_wb = 1'b0;
    checks++; if (halted !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL stop_halt_race got halt=%b run=%b exp 1/0", halted, running); end
  endtask

  task automatic test_step_mid_run();
    do_reset();
    issue(RUN, 8'd0);
    tick();
    tick();
    issue(STEP, 8'd3);
    checks++; if (running !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL step_mid_run got run=%b rdy=%b exp 1/1", running, cmd_ready); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (running !== 1'b1 || step_done !== 1'b0 || cycle_count !== 32'd8) begin errors++; $display("FAIL run_continues got run=%b done=%b cnt=%0d exp 1/0/8", running, step_done, cycle_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    issue(RUN, 8'd0);
    for (int i = 0; i < 19; i++) tick();
    issue(STOP, 8'd0);
    checks++; if (cycle_count4 !== 4'd4) begin errors++; $display("FAIL wrap_count4 got %0d exp 4", cycle_count4); end
    checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL wrap_count32 got %0d exp 20", cycle_count); end
  endtask

  task automatic test_reset_mid_step();
    do_reset();
    issue(STEP, 8'd10);
    tick();
    tick();
    do_reset();
    checks++; if (step !== 1'b0 || cmd_ready !== 1'b1 || step_done !== 1'b0) begin errors++; $display("FAIL rst_mid_step got step=%b rdy=%b done=%b exp 0/1/0", step, cmd_ready, step_done); end
    checks++; if (running !== 1'b0 || halted !== 1'b0 || cycle_count !== 32'd0) begin errors++; $display("FAIL rst_mid_step_state got run=%b halt=%b cnt=%0d exp 0/0/0", running, halted, cycle_count); end
    tick();
    checks++; if (step !== 1'b0 || step_done !== 1'b0) begin errors++; $display("FAIL rst_abort got step=%b done=%b exp 0/0", step, step_done); end
  endtask

  // Reference model: tracks the controller as a mode plus remaining burst length.
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

  task automatic test_random();
    mode_t       mode = M_IDLE;
    int          left = 0;
    bit          done = 0;
    longint      cnt  = 0;
    logic [7:0]  n;
    logic [1:0]  c;
    bit          v, h, r, took;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 2) == 0);
      c = 2'($urandom_range(0, 3));
      n = 8'($urandom_range(0, 6));
      h = ($urandom_range(0, 11) == 0);
      rst = r; cmd_valid = v; cmd = c; step_count = n; halt_wb = h;
      if (r) begin
        mode = M_IDLE; left = 0; done = 0; cnt = 0;
      end else begin
        done = 0;
        if (mode == M_RUN || mode == M_STEP) cnt = (cnt + 1) % (64'd1 << 32);
        took = v && (mode != M_STEP);
        case (mode)
          M_IDLE: if (took && c == RUN) mode = M_RUN;
                  else if (took && c == STEP) begin mode = M_STEP; left = (n == 0) ? 1 : int'(n); end
          M_RUN:  if (h) mode = M_HALT; else if (took && c == STOP) mode = M_IDLE;
          M_STEP: begin
                    left = left - 1;
                    if (h) begin mode = M_HALT; done = 1; end
                    else if (left == 0) begin mode = M_IDLE; done = 1; end
                  end
          M_HALT: if (took && c == STOP) mode = M_IDLE;
          default: mode = M_IDLE;
        endcase
      end
      tick();
      checks++; if (step !== (mode == M_RUN || mode == M_STEP)) begin errors++; $display("FAIL rnd_step cyc%0d got %b exp %b", cyc, step, (mode == M_RUN || mode == M_STEP)); end
      checks++; if (cmd_ready !== (mode != M_STEP)) begin errors++; $display("FAIL rnd_ready cyc%0d got %b exp %b", cyc, cmd_ready, (mode != M_STEP)); end
      checks++; if (running !== (mode == M_RUN) || halted !== (mode == M_HALT)) begin errors++; $display("FAIL rnd_mode cyc%0d got run=%b halt=%b exp %b/%b", cyc, running, halted, (mode == M_RUN), (mode == M_HALT)); end
      checks++; if (step_done !== done) begin errors++; $display("FAIL rnd_done cyc%0d got %b exp %b", cyc, step_done, done); end
      checks++; if (cycle_count !== 32'(cnt)) begin errors++; $display("FAIL rnd_count cyc%0d got %0d exp %0d", cyc, cycle_count, cnt); end
    end
    rst = 1'b0; cmd_valid = 1'b0; cmd = NOP; step_count = 8'd0; halt_wb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = NOP; step_count = 8'd0; halt_wb = 1'b0;
    tick();
    test_reset();
    test_run_halt();
    test_step_n(8'd3, 3);
    test_step_n(8'd0, 1);
    test_step_halt();
    test_run_stop_halt();
    test_step_mid_run();
    test_wrap();
    test_reset_mid_step();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_exec_controller.md
Name: pipeline_exec_controller

Overview:
- Execution sequencer for the MIPS pipeline. Drives the shared `i_step` enable of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Takes run, step-N and stop commands from the debug unit, and freezes the pipeline when a HALT instruction reaches write-back.
- Counts executed clock cycles and reports completion to the debug unit.

Parameters:
- NB_CYCLES, 32, width of the executed-cycle counter.
- NB_STEPS, 8, width of the step-count field of a STEP command.

Ports:
- i_clk  in  1  system clock. Controller updates on posedge; pipeline registers sample o_step on negedge.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command strobe from the debug unit.
- i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 STOP.
- i_step_count  in  NB_STEPS  cycle count for STEP; 0 is treated as 1.
- i_halt_wb  in  1  HALT instruction present in the WB stage (level).
- o_cmd_ready  out  1  command accepted when i_cmd_valid and o_cmd_ready are both high at a posedge.
- o_step  out  1  pipeline advance enable.
- o_running  out  1  state == RUN.
- o_halted  out  1  state == HALTED.
- o_step_done  out  1  one-cycle pulse when a STEP burst ends.
- o_cycle_count  out  NB_CYCLES  number of cycles with o_step high.

Behaviour:
- All state and outputs are registered on posedge i_clk. A command accepted at edge k gives o_step high from cycle k+1.
- Reset values (synchronous, i_reset high at posedge):
  - state IDLE, remaining 0, o_cycle_count 0.
  - o_step 0, o_step_done 0, o_running 0, o_halted 0, o_cmd_ready 1.
  - Reset overrides any command or halt in the same cycle. Reset mid-RUN or mid-STEP aborts the burst immediately.
- o_step = (state == RUN) or (state == STEP). It is derived from the registered state only, so it is stable across the negedge.
- o_cmd_ready is 1 in IDLE, RUN and HALTED, and 0 in STEP. A valid command while not ready is dropped, not queued.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP, with remaining = max(i_step_count, 1).
  - STOP and NOP -> stay in IDLE.
  - i_halt_wb is ignored.
- RUN:
  - i_halt_wb = 1 -> HALTED. The cycle in which halt is sampled still counts as a step cycle.
  - Otherwise STOP -> IDLE.
  - RUN and STEP commands are ignored.
  - Halt and STOP in the same cycle: halt wins.
- STEP:
  - Each cycle, remaining is decremented.
  - i_halt_wb = 1 -> HALTED, and o_step_done pulses.
  - Else if remaining == 1 -> IDLE, and o_step_done pulses. The pulse is high exactly in the first cycle after the burst.
  - o_step is therefore high for exactly N cycles unless a halt occurs first.
- HALTED:
  - o_step is 0.
  - STOP -> IDLE. o_cycle_count is kept.
  - RUN and STEP are ignored; i_halt_wb is ignored.
- o_cycle_count increments by 1 on each posedge where o_step == 1. It wraps modulo 2^NB_CYCLES with no saturation. Only i_reset clears it.
- Illegal or unused encodings: none (all 2-bit codes are defined). NOP never changes state.

Test Plan:
- Reset, then RUN accepted at edge 0, i_halt_wb raised before edge 10 -> o_step high in cycles 1..10, o_halted = 1 from cycle 11, o_cycle_count = 10, o_running = 0.
- From IDLE, STEP with i_step_count = 3 -> o_step high for exactly 3 cycles, o_cmd_ready = 0 during the burst, o_step_done = 1 for one cycle after it, state IDLE, o_cycle_count = 3.
- STEP with i_step_count = 0 -> exactly 1 step cycle, then o_step_done pulse.
- STEP 5 with halt asserted during the 2nd step cycle -> 2 step cycles, o_step_done pulse, o_halted = 1. A subsequent RUN is ignored; STOP returns to IDLE with o_cycle_count = 2.
- During RUN, assert STOP and i_halt_wb in the same cycle -> HALTED, not IDLE. STEP issued mid-RUN -> ignored and the run continues.
- Preload the counter near wrap (NB_CYCLES = 4 build) and run 20 cycles -> count wraps to 4. Assert i_reset mid-STEP -> all outputs at reset values next cycle and o_cmd_ready = 1.
